// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W    = 128,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                SKID      = 1'b1,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               in_fire;
    logic               out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;
    // Skid mode breaks the out_ready -> in_ready path with a flop
    assign in_ready  = SKID ? in_ready_q : (out_ready | ~out_valid);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        if (SKID) begin
                            state_d = TWO;
                            skid_d  = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance (CNT_W=4, non-zero
// reset value) and a single-entry instance.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    logic        ns_in_valid, ns_in_ready, ns_flush, ns_out_valid, ns_out_ready;
    logic [31:0] ns_in_data, ns_out_data;
    logic [1:0]  ns_occ;
    logic [15:0] ns_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(32), .RESET_VAL(32'h0), .SKID(1'b0), .CNT_W(16)
    ) u_ns (
        .clk(clk), .reset(reset),
        .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_data(ns_in_data),
        .flush(ns_flush),
        .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_data(ns_out_data),
        .occupancy(ns_occ), .stall_cnt(ns_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;
        bit tog;
        reset = 1'b0;
        in_valid = 0; in_data = 0; flush = 0; out_ready = 0;
        ns_in_valid = 0; ns_in_data = 0; ns_flush = 0; ns_out_ready = 0;

        // reset values while reset is held low
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_data", out_data, RV);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("ns_rst_ready", 32'(ns_in_ready), 32'd1);
        chk("ns_rst_data", ns_out_data, 32'h0);
        reset = 1'b1;

        // first transfer, one-cycle latency
        in_valid = 1; in_data = 32'hA; out_ready = 1;
        step();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", out_data, 32'hA);
        chk("first_occ", 32'(occupancy), 32'd1);
        in_valid = 0;
        step();
        chk("first_drain", 32'(occupancy), 32'd0);

        // fill skid buffer, then drain
        out_ready = 0; in_valid = 1; in_data = 32'h1;
        step();
        chk("fill1_occ", 32'(occupancy), 32'd1);
        in_data = 32'h2;
        step();
        chk("fill2_occ", 32'(occupancy), 32'd2);
        chk("fill2_ready", 32'(in_ready), 32'd0);
        chk("fill2_data", out_data, 32'h1);
        in_valid = 0; out_ready = 1;
        step();
        chk("drain1_occ", 32'(occupancy), 32'd1);
        chk("drain1_data", out_data, 32'h2);
        chk("drain1_ready", 32'(in_ready), 32'd1);
        step();
        chk("drain2_occ", 32'(occupancy), 32'd0);
        chk("drain2_valid", 32'(out_valid), 32'd0);
        chk("fill_stall", 32'(stall_cnt), 32'd1);

        // stream with out_ready toggling every cycle
        sent = 0; got = 0; tog = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 16; cyc++) begin
            in_valid  = (sent < 16);
            in_data   = 32'h10 + 32'(sent);
            out_ready = tog;
            tog = ~tog;
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                chk("stream_data", out_data, 32'h10 + 32'(got));
                got++;
            end
            step();
        end
        in_valid = 0;
        chk("stream_count", 32'(got), 32'd16);
        chk("stream_occ", 32'(occupancy), 32'd0);

        // flush while full with a concurrent push
        out_ready = 0; in_valid = 1; in_data = 32'h33;
        step();
        in_data = 32'h44;
        step();
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        flush = 1; in_data = 32'h55;
        step();
        flush = 0; in_valid = 0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", out_data, RV);
        chk("flush_ready", 32'(in_ready), 32'd1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_emit", 32'(out_valid), 32'd0);
        end

        // asynchronous reset while full
        out_ready = 0; in_valid = 1; in_data = 32'h61;
        step();
        in_data = 32'h62;
        step();
        chk("pre_rst_occ", 32'(occupancy), 32'd2);
        reset = 1'b0;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_data", out_data, RV);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b1;

        // stall counter: survives flush, saturates at 15
        in_valid = 1; in_data = 32'h99; out_ready = 0;
        step();
        chk("resume_data", out_data, 32'h99);
        chk("stall0", 32'(stall_cnt), 32'd0);
        in_valid = 0;
        repeat (5) step();
        chk("stall5", 32'(stall_cnt), 32'd5);
        flush = 1;
        step();
        flush = 0;
        chk("stall_flush", 32'(stall_cnt), 32'd6);
        chk("stall_flush_occ", 32'(occupancy), 32'd0);
        in_valid = 1; in_data = 32'h77;
        step();
        in_valid = 0;
        repeat (20) step();
        chk("stall_sat", 32'(stall_cnt), 32'd15);
        out_ready = 1;
        step();
        chk("stall_hold", 32'(stall_cnt), 32'd15);
        chk("stall_drain", 32'(occupancy), 32'd0);

        // single-entry mode: combinational ready, pass-through replace
        ns_in_valid = 1; ns_in_data = 32'h3; ns_out_ready = 0;
        step();
        ns_in_valid = 0;
        chk("ns_occ1", 32'(ns_occ), 32'd1);
        chk("ns_data3", ns_out_data, 32'h3);
        chk("ns_ready0", 32'(ns_in_ready), 32'd0);
        ns_out_ready = 1;
        #1;
        chk("ns_ready1", 32'(ns_in_ready), 32'd1);
        ns_in_valid = 1; ns_in_data = 32'h7;
        step();
        ns_in_valid = 0;
        chk("ns_data7", ns_out_data, 32'h7);
        chk("ns_occ_replace", 32'(ns_occ), 32'd1);
        step();
        chk("ns_drain", 32'(ns_occ), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
